// File: rtl/nnrv_pkg.sv
// Shared nnrv definitions: loader state encoding, default widths and the
// byte-mask to lane-mask helper used by the RAM and the MEM stage.
package nnrv_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int XLEN_DEF       = 32;

  typedef enum logic {
    LD_LOAD = 1'b0,
    LD_RUN  = 1'b1
  } ld_state_e;

  function automatic logic [31:0] mask_expand(input logic [3:0] i_mask);
    logic [31:0] w_lanes;
    w_lanes = '0;
    for (int b = 0; b < 4; b++) begin
      w_lanes[8*b +: 8] = {8{i_mask[b]}};
    end
    return w_lanes;
  endfunction

endpackage

// File: rtl/nnrv_ram_loader.sv
// Boot loader: packs a little-endian byte stream into words and issues
// full-word write requests while holding the core.
//
// state   | meaning
// LD_LOAD | accepting image bytes, core held, ld_ready high
// LD_RUN  | image done, loader inputs ignored until reset
module nnrv_ram_loader
  import nnrv_pkg::*;
#(
  parameter int WORD_AW   = 6,
  parameter bit BOOT_LOAD = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ld_valid,
  input  logic [7:0]         i_ld_data,
  input  logic               i_ld_last,
  output logic               o_ld_ready,
  output logic               o_core_hold,
  output logic               o_run,
  output logic               o_wr_en,
  output logic [WORD_AW-1:0] o_wr_addr,
  output logic [31:0]        o_wr_data
);

  localparam ld_state_e RST_STATE = BOOT_LOAD ? LD_LOAD : LD_RUN;

  ld_state_e          r_state;
  ld_state_e          w_state_nxt;
  logic [1:0]         r_byte_cnt;
  logic [WORD_AW-1:0] r_word_ptr;
  logic [31:0]        r_asm;
  logic               r_core_hold;
  logic               w_accept;
  logic               w_word_done;
  logic [31:0]        w_asm_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= RST_STATE;
      r_core_hold <= BOOT_LOAD;
    end else begin
      r_state     <= w_state_nxt;
      r_core_hold <= (w_state_nxt == LD_LOAD);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ld_ready  = 1'b0;
    o_run       = 1'b0;
    case (r_state)
      LD_LOAD: begin
        o_ld_ready = 1'b1;
        if (i_ld_valid && i_ld_last) w_state_nxt = LD_RUN;
      end
      LD_RUN: begin
        o_run = 1'b1;
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  assign w_accept    = i_ld_valid & o_ld_ready;
  assign w_word_done = w_accept & ((r_byte_cnt == 2'd3) | i_ld_last);
  assign w_asm_nxt   = r_asm | (32'(i_ld_data) << {r_byte_cnt, 3'b000});

  // A reset edge discards the partially assembled word instead of writing it.
  assign o_wr_en     = w_word_done & i_rst_n;
  assign o_wr_addr   = r_word_ptr;
  assign o_wr_data   = w_asm_nxt;
  assign o_core_hold = r_core_hold;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_byte_cnt <= '0;
      r_word_ptr <= '0;
      r_asm      <= '0;
    end else if (w_accept) begin
      if (w_word_done) begin
        r_byte_cnt <= '0;
        r_asm      <= '0;
        r_word_ptr <= r_word_ptr + 1'b1;
      end else begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
        r_asm      <= w_asm_nxt;
      end
    end
  end

endmodule

// File: rtl/nnrv_ram.sv
// Unified instruction/data RAM: boot loader write path, masked MEM stores,
// and two independent combinational byte-masked read ports.
module nnrv_ram
  import nnrv_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int INSTR_WIDTH = 32,
  parameter int XLEN        = XLEN_DEF,
  parameter bit BOOT_LOAD   = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [ADDR_WIDTH-1:0]  i_if_rd_addr,
  input  logic                   i_if_rd_en,
  input  logic [3:0]             i_if_rd_mask,
  output logic [INSTR_WIDTH-1:0] o_if_rd_data,
  input  logic [ADDR_WIDTH-1:0]  i_mem_addr,
  input  logic                   i_mem_rd_en,
  input  logic                   i_mem_wr_en,
  input  logic [3:0]             i_mem_mask,
  input  logic [XLEN-1:0]        i_mem_wr_data,
  output logic [XLEN-1:0]        o_mem_rd_data,
  input  logic                   i_ld_valid,
  input  logic [7:0]             i_ld_data,
  input  logic                   i_ld_last,
  output logic                   o_ld_ready,
  output logic                   o_core_hold
);

  localparam int WORD_AW = ADDR_WIDTH - 2;
  localparam int DEPTH   = 1 << WORD_AW;

  logic [XLEN-1:0]    r_mem [DEPTH];
  logic [WORD_AW-1:0] w_if_idx;
  logic [WORD_AW-1:0] w_mem_idx;
  logic               w_run;
  logic               w_ld_wr_en;
  logic [WORD_AW-1:0] w_ld_wr_addr;
  logic [31:0]        w_ld_wr_data;
  logic               w_unused_addr_bits;

  assign w_if_idx           = i_if_rd_addr[ADDR_WIDTH-1:2];
  assign w_mem_idx          = i_mem_addr[ADDR_WIDTH-1:2];
  assign w_unused_addr_bits = ^{i_if_rd_addr[1:0], i_mem_addr[1:0]};

  nnrv_ram_loader #(
    .WORD_AW   (WORD_AW),
    .BOOT_LOAD (BOOT_LOAD)
  ) u_loader (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ld_valid  (i_ld_valid),
    .i_ld_data   (i_ld_data),
    .i_ld_last   (i_ld_last),
    .o_ld_ready  (o_ld_ready),
    .o_core_hold (o_core_hold),
    .o_run       (w_run),
    .o_wr_en     (w_ld_wr_en),
    .o_wr_addr   (w_ld_wr_addr),
    .o_wr_data   (w_ld_wr_data)
  );

  // Array is deliberately not reset; the loader owns the write port in LOAD.
  always_ff @(posedge i_clk) begin
    if (w_ld_wr_en) begin
      r_mem[w_ld_wr_addr] <= XLEN'(w_ld_wr_data);
    end else if (w_run && i_mem_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_mem_mask[b]) r_mem[w_mem_idx][8*b +: 8] <= i_mem_wr_data[8*b +: 8];
      end
    end
  end

  assign o_if_rd_data  = i_if_rd_en ?
                         (INSTR_WIDTH'(r_mem[w_if_idx]) & INSTR_WIDTH'(mask_expand(i_if_rd_mask))) : '0;
  assign o_mem_rd_data = i_mem_rd_en ?
                         (r_mem[w_mem_idx] & XLEN'(mask_expand(i_mem_mask))) : '0;

endmodule

// File: tb/tb_nnrv_ram.sv
// Scoreboarded bench for nnrv_ram: a byte/word reference model predicts read
// data, a negedge monitor pops expectations whenever a read is presented.
module tb_nnrv_ram;

  localparam int DA = 64;
  localparam int DB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_if_en, a_mem_rd, a_mem_wr, a_ld_valid, a_ld_last, a_ld_ready, a_hold;
  logic [7:0]  a_if_addr, a_mem_addr, a_ld_data;
  logic [3:0]  a_if_mask, a_mem_mask;
  logic [31:0] a_if_data, a_mem_wdata, a_mem_data;

  logic        b_rst_n, b_if_en, b_mem_rd, b_mem_wr, b_ld_valid, b_ld_last, b_ld_ready, b_hold;
  logic [3:0]  b_if_addr, b_mem_addr;
  logic [7:0]  b_ld_data;
  logic [3:0]  b_if_mask, b_mem_mask;
  logic [31:0] b_if_data, b_mem_wdata, b_mem_data;

  nnrv_ram #(.ADDR_WIDTH(8), .INSTR_WIDTH(32), .XLEN(32), .BOOT_LOAD(1'b1)) u_dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n),
    .i_if_rd_addr(a_if_addr), .i_if_rd_en(a_if_en), .i_if_rd_mask(a_if_mask), .o_if_rd_data(a_if_data),
    .i_mem_addr(a_mem_addr), .i_mem_rd_en(a_mem_rd), .i_mem_wr_en(a_mem_wr), .i_mem_mask(a_mem_mask),
    .i_mem_wr_data(a_mem_wdata), .o_mem_rd_data(a_mem_data),
    .i_ld_valid(a_ld_valid), .i_ld_data(a_ld_data), .i_ld_last(a_ld_last),
    .o_ld_ready(a_ld_ready), .o_core_hold(a_hold)
  );

  nnrv_ram #(.ADDR_WIDTH(4), .INSTR_WIDTH(32), .XLEN(32), .BOOT_LOAD(1'b1)) u_dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n),
    .i_if_rd_addr(b_if_addr), .i_if_rd_en(b_if_en), .i_if_rd_mask(b_if_mask), .o_if_rd_data(b_if_data),
    .i_mem_addr(b_mem_addr), .i_mem_rd_en(b_mem_rd), .i_mem_wr_en(b_mem_wr), .i_mem_mask(b_mem_mask),
    .i_mem_wr_data(b_mem_wdata), .o_mem_rd_data(b_mem_data),
    .i_ld_valid(b_ld_valid), .i_ld_data(b_ld_data), .i_ld_last(b_ld_last),
    .o_ld_ready(b_ld_ready), .o_core_hold(b_hold)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] ma [DA];
  logic [3:0]  ka [DA];
  logic [31:0] mb [DB];
  logic [7:0]  tb_bytes [32];

  logic [31:0] q_aif [$];
  logic [31:0] q_amem [$];
  logic [31:0] q_bif [$];
  bit chk_a = 1'b0;
  bit chk_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] v, input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = v[8*b +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_a) begin
      if (q_aif.size() == 0 || q_amem.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_scoreboard_underflow actual=empty required=entry");
      end else begin
        check("a_fetch", a_if_data, q_aif.pop_front());
        check("a_load", a_mem_data, q_amem.pop_front());
      end
    end
    if (chk_b) begin
      if (q_bif.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_scoreboard_underflow actual=empty required=entry");
      end else begin
        check("b_fetch", b_if_data, q_bif.pop_front());
      end
    end
  end

  // One cycle on DUT A: both read ports plus optional store; model updates after the edge.
  task automatic a_cycle(input bit if_en, input int fw, input logic [3:0] fm,
                         input bit rd_en, input bit wr_en, input int mw,
                         input logic [3:0] mm, input logic [31:0] wd);
    logic [5:0] fwi, mwi;
    fwi = 6'(fw);
    mwi = 6'(mw);
    a_if_en     = if_en;
    a_if_addr   = {fwi, 2'($urandom_range(0, 3))};
    a_if_mask   = fm;
    a_mem_rd    = rd_en;
    a_mem_wr    = wr_en;
    a_mem_addr  = {mwi, 2'($urandom_range(0, 3))};
    a_mem_mask  = mm;
    a_mem_wdata = wd;
    q_aif.push_back(if_en ? lanes(ma[fw], fm) : 32'h0);
    q_amem.push_back(rd_en ? lanes(ma[mw], mm) : 32'h0);
    chk_a = 1'b1;
    @(posedge clk); #1;
    chk_a = 1'b0;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mm[b]) begin
          ma[mw][8*b +: 8] = wd[8*b +: 8];
          ka[mw][b] = 1'b1;
        end
      end
    end
    a_if_en = 1'b0; a_mem_rd = 1'b0; a_mem_wr = 1'b0;
  endtask

  task automatic b_read(input int w);
    b_if_en   = 1'b1;
    b_if_addr = {2'(w), 2'($urandom_range(0, 3))};
    b_if_mask = 4'hF;
    q_bif.push_back(mb[w]);
    chk_b = 1'b1;
    @(posedge clk); #1;
    chk_b = 1'b0;
    b_if_en = 1'b0;
  endtask

  // Streams tb_bytes[0..n-1]; the model then places each 4-byte group (or the
  // final partial group when last is sent) at group index modulo depth.
  task automatic stream(input bit sel, input int n, input bit with_last);
    int cnt;
    logic [31:0] word;
    for (int i = 0; i < n; i++) begin
      if (!sel) begin
        a_ld_valid = 1'b1; a_ld_data = tb_bytes[i]; a_ld_last = with_last && (i == n - 1);
      end else begin
        b_ld_valid = 1'b1; b_ld_data = tb_bytes[i]; b_ld_last = with_last && (i == n - 1);
      end
      @(negedge clk);
      if (!sel) check("a_hold_ready_load", {30'b0, a_hold, a_ld_ready}, 32'h3);
      else      check("b_hold_ready_load", {30'b0, b_hold, b_ld_ready}, 32'h3);
      @(posedge clk); #1;
    end
    a_ld_valid = 1'b0; a_ld_last = 1'b0; b_ld_valid = 1'b0; b_ld_last = 1'b0;
    for (int k = 0; 4 * k < n; k++) begin
      cnt = (n - 4 * k >= 4) ? 4 : n - 4 * k;
      if (cnt == 4 || with_last) begin
        word = '0;
        for (int j = 0; j < cnt; j++) word = word + (32'(tb_bytes[4*k+j]) << (8 * j));
        if (!sel) begin
          ma[k % DA] = word; ka[k % DA] = 4'hF;
        end else begin
          mb[k % DB] = word;
        end
      end
    end
  endtask

  task automatic a_reset_pulse();
    a_rst_n = 1'b0;
    @(posedge clk); #1;
    a_rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rw;
    int fw, mw;
    logic [3:0] fm, mm;
    bit fe, re, we;

    for (int i = 0; i < DA; i++) begin ma[i] = '0; ka[i] = '0; end
    for (int i = 0; i < DB; i++) mb[i] = '0;
    a_rst_n = 0; a_if_en = 0; a_mem_rd = 0; a_mem_wr = 0; a_ld_valid = 0; a_ld_last = 0;
    a_if_addr = 0; a_mem_addr = 0; a_ld_data = 0; a_if_mask = 0; a_mem_mask = 0; a_mem_wdata = 0;
    b_rst_n = 0; b_if_en = 0; b_mem_rd = 0; b_mem_wr = 0; b_ld_valid = 0; b_ld_last = 0;
    b_if_addr = 0; b_mem_addr = 0; b_ld_data = 0; b_if_mask = 0; b_mem_mask = 0; b_mem_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    a_rst_n = 1; b_rst_n = 1;
    @(negedge clk);
    check("a_reset_hold_ready", {30'b0, a_hold, a_ld_ready}, 32'h3);
    check("b_reset_hold_ready", {30'b0, b_hold, b_ld_ready}, 32'h3);
    @(posedge clk); #1;
    a_cycle(0, 0, 4'hF, 0, 0, 0, 4'hF, 32'h0);

    // Boot image
    tb_bytes[0] = 8'h13; tb_bytes[1] = 8'h00; tb_bytes[2] = 8'h00;
    tb_bytes[3] = 8'h00; tb_bytes[4] = 8'hB7; tb_bytes[5] = 8'h10;
    stream(0, 6, 1);
    @(negedge clk);
    check("a_hold_ready_after_boot", {30'b0, a_hold, a_ld_ready}, 32'h0);
    @(posedge clk); #1;
    a_cycle(1, 0, 4'hF, 1, 0, 1, 4'hF, 32'h0);

    // Masked store
    a_cycle(0, 0, 4'h0, 0, 1, 2, 4'hF, 32'hFFFF_FFFF);
    a_cycle(0, 0, 4'h0, 0, 1, 2, 4'h5, 32'h1234_5678);
    a_cycle(1, 2, 4'hF, 1, 0, 2, 4'hF, 32'h0);

    // Loader inputs ignored in RUN
    a_ld_valid = 1; a_ld_data = 8'h5A; a_ld_last = 1;
    repeat (3) begin
      @(negedge clk);
      check("a_hold_ready_run", {30'b0, a_hold, a_ld_ready}, 32'h0);
      @(posedge clk); #1;
    end
    a_ld_valid = 0; a_ld_last = 0;
    a_cycle(1, 2, 4'hF, 1, 0, 1, 4'hF, 32'h0);
    a_cycle(1, 0, 4'hF, 0, 0, 0, 4'h0, 32'h0);

    // Same-cycle read/write of word 3
    a_cycle(0, 0, 4'h0, 0, 1, 3, 4'hF, 32'h0102_0304);
    a_cycle(1, 3, 4'hF, 1, 1, 3, 4'hF, 32'hAAAA_5555);
    a_cycle(1, 3, 4'hF, 1, 0, 3, 4'hF, 32'h0);

    // Read masking
    a_cycle(0, 0, 4'h0, 0, 1, 4, 4'hF, 32'hDEAD_BEEF);
    a_cycle(1, 4, 4'h3, 0, 0, 4, 4'hF, 32'h0);
    a_cycle(1, 4, 4'hC, 1, 0, 4, 4'h6, 32'h0);

    // Random traffic over words 0..15
    for (int n = 0; n < 300; n++) begin
      fw = $urandom_range(0, 15);
      mw = $urandom_range(0, 15);
      fe = 1'($urandom);
      re = 1'($urandom);
      we = 1'($urandom);
      fm = 4'($urandom) & ka[fw];
      mm = 4'($urandom);
      rw = $urandom;
      if (re) begin
        we = 1'b0;
        mm = mm & ka[mw];
      end
      a_cycle(fe, fw, fm, re, we, mw, mm, rw);
    end

    // Reset mid-load with a MEM store attempted during LOAD
    a_reset_pulse();
    a_mem_wr = 1; a_mem_addr = 8'h04; a_mem_mask = 4'hF; a_mem_wdata = 32'h0;
    for (int i = 0; i < 5; i++) tb_bytes[i] = 8'($urandom);
    stream(0, 5, 0);
    a_mem_wr = 0;
    a_reset_pulse();
    a_cycle(1, 1, 4'hF, 1, 0, 0, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) tb_bytes[i] = 8'($urandom);
    stream(0, 4, 1);
    @(negedge clk);
    check("a_hold_after_reload", {30'b0, a_hold, a_ld_ready}, 32'h0);
    @(posedge clk); #1;
    a_cycle(1, 0, 4'hF, 1, 0, 1, 4'hF, 32'h0);
    a_cycle(1, 2, 4'hF, 1, 0, 4, 4'hF, 32'h0);

    // Wrap on a 4-word instance
    for (int i = 0; i < 20; i++) tb_bytes[i] = 8'($urandom);
    stream(1, 20, 1);
    @(negedge clk);
    check("b_hold_after_boot", {30'b0, b_hold, b_ld_ready}, 32'h0);
    @(posedge clk); #1;
    for (int w = 0; w < DB; w++) b_read(w);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(q_aif.size() + q_amem.size() + q_bif.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
